// File: rtl/mem_bridge.sv
// -----------------------------------------------------------------------------
// mem_bridge
//
// Bridges a CPU-side level-held memory request (mem_read / mem_write held by
// the control unit until mem_resp) onto a strobe/response physical-memory
// port. One transaction is in flight at a time, tracked by a three-state FSM:
//
//   IDLE : sample the CPU request and latch address / data / mask.
//   BUSY : drive exactly one pmem strobe and hold the pmem_* fields stable
//          until pmem_resp.
//   RESP : one-cycle mem_resp (and mem_err when the transaction aborted).
//
// A write whose byte-enable mask is all zero touches no bytes, so it skips
// BUSY and completes directly (IDLE -> RESP).
//
// Optional feature (compile-time macro MEM_BRIDGE_TIMEOUT_EN):
//   A BUSY-cycle counter aborts a stalled transaction after TIMEOUT_CYCLES
//   cycles without pmem_resp. The abort completes with mem_resp + mem_err,
//   and a timed-out read returns 32'h0. Without the macro there is no
//   counter, mem_err is tied low and BUSY waits for pmem_resp indefinitely.
//
// Parameters
//   TIMEOUT_CYCLES  BUSY cycles before an abort (>= 1; used only with the
//                   timeout macro). Counter is 8 bits up to 255, else 16.
//
// Ports
//   clk              single clock, rising edge
//   rst              synchronous reset, active low
//   mem_read         CPU read request (level)
//   mem_write        CPU write request (level, wins over mem_read)
//   mem_address      CPU word-aligned address
//   mem_wdata        CPU write data, already lane-shifted
//   mem_byte_enable  CPU write lane mask
//   mem_resp         one-cycle completion pulse
//   mem_rdata        registered read data, held until the next read completes
//   mem_err          one-cycle abort flag, coincident with mem_resp
//   pmem_read        physical read strobe
//   pmem_write       physical write strobe
//   pmem_address     registered physical address
//   pmem_wdata       registered physical write data
//   pmem_wmask       registered physical write mask
//   pmem_resp        physical completion, one cycle
//   pmem_rdata       physical read data, valid with pmem_resp
// -----------------------------------------------------------------------------
module mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_wmask,
  input  logic        pmem_resp,
  input  logic [31:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        is_write;     // operation latched in IDLE
  logic [31:0] rdata_q;
  logic        timeout_hit;  // abort condition, evaluated in BUSY only

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_next; no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (mem_write) begin
          // An empty mask moves no data: complete without a physical access.
          state_next = (mem_byte_enable == 4'b0000) ? RESP : BUSY;
        end else if (mem_read) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (pmem_resp || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; it is not in the
    // sensitivity list, so an in-flight transaction is dropped at that edge.
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register in the design sees pre-edge values of the others.
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch and read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      is_write     <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      pmem_wmask   <= '0;
      rdata_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_write) begin
            is_write     <= 1'b1;
            pmem_address <= mem_address;
            pmem_wdata   <= mem_wdata;
            pmem_wmask   <= mem_byte_enable;
          end else if (mem_read) begin
            is_write     <= 1'b0;
            pmem_address <= mem_address;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            if (!is_write) begin
              rdata_q <= pmem_rdata;
            end
          end else if (timeout_hit && !is_write) begin
            // An aborted read must not return stale data from the last read.
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Stall timeout
  // ---------------------------------------------------------------------------
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  // The abort fires on the edge that advances the counter to TIMEOUT_CYCLES,
  // i.e. after TIMEOUT_CYCLES BUSY cycles without pmem_resp.
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             err_q;

  // pmem_resp in the final cycle takes precedence over the abort.
  assign timeout_hit = (state == BUSY) && !pmem_resp && (count == COUNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE) begin
        count <= '0;
        err_q <= 1'b0;
      end else if (state == BUSY && !pmem_resp) begin
        count <= count + CNT_W'(1);
        if (timeout_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign mem_err = (state == RESP) && err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs decoded from state
  // ---------------------------------------------------------------------------
  assign pmem_read  = (state == BUSY) && !is_write;
  assign pmem_write = (state == BUSY) &&  is_write;
  assign mem_resp   = (state == RESP);
  assign mem_rdata  = rdata_q;

endmodule
